// File: rtl/sumador_cla_segmentado_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// slave is the adder's view and master is the view of the block that drives it.
interface sumador_cla_segmentado_if #(
  parameter int N = 32
);
  logic         valid_in;
  logic         ready_out;
  logic [N-1:0] Operando1;
  logic [N-1:0] Operando2;
  logic         CarryIn;
  logic         Modo;
  logic         valid_out;
  logic         ready_in;
  logic [N-1:0] Resultado;
  logic         CarryOut;
  logic         Overflow;
  logic         Cero;
  logic         Negativo;

  modport slave (
    input  valid_in, Operando1, Operando2, CarryIn, Modo, ready_in,
    output ready_out, valid_out, Resultado, CarryOut, Overflow, Cero, Negativo
  );

  modport master (
    output valid_in, Operando1, Operando2, CarryIn, Modo, ready_in,
    input  ready_out, valid_out, Resultado, CarryOut, Overflow, Cero, Negativo
  );
endinterface

// File: rtl/sumador_cla_segmentado.sv
// Pipelined carry-lookahead adder/subtractor.
// Stage k resolves operand segment k with a two-level CLA. It forwards three things:
//   - the lower-segment sums,
//   - the carry into the next segment,
//   - the still-unprocessed upper operand bits.
// Each stage only keeps the operand bits it has not yet consumed.
// The last stage registers the result together with the ALU flags.
module sumador_cla_segmentado #(
  parameter int N      = 32,
  parameter int ETAPAS = 4,
  parameter int BLOQUE = 4
) (
  input  logic clk,
  input  logic rst,
  sumador_cla_segmentado_if.slave bus
);

  localparam int SEG = N / ETAPAS;
  localparam int NG  = SEG / BLOQUE;

  // Two-level CLA over one segment. Every carry is a flat sum of products of
  // generate/propagate terms, so no carry ripples between groups.
  function automatic logic [SEG:0] cla_seg(
    input logic [SEG-1:0] a,
    input logic [SEG-1:0] b,
    input logic           cin
  );
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG-1:0] c;
    logic [NG-1:0]  gg;
    logic [NG-1:0]  gp;
    logic [NG:0]    gc;
    logic           term;
    logic           acc;
    g = a & b;
    p = a | b;
    // group generate / propagate
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < BLOQUE; i++) begin
        gg[j] = g[j*BLOQUE+i] | (p[j*BLOQUE+i] & gg[j]);
        gp[j] = gp[j] & p[j*BLOQUE+i];
      end
    end
    // group carries
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      acc = cin;
      for (int m = 0; m <= j; m++) acc = acc & gp[m];
      for (int i = 0; i <= j; i++) begin
        term = gg[i];
        for (int m = i + 1; m <= j; m++) term = term & gp[m];
        acc = acc | term;
      end
      gc[j+1] = acc;
    end
    // bit carries inside each group, looked ahead from the group carry-in
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < BLOQUE; i++) begin
        acc = gc[j];
        for (int m = 0; m < i; m++) acc = acc & p[j*BLOQUE+m];
        for (int l = 0; l < i; l++) begin
          term = g[j*BLOQUE+l];
          for (int m = l + 1; m < i; m++) term = term & p[j*BLOQUE+m];
          acc = acc | term;
        end
        c[j*BLOQUE+i] = acc;
      end
    end
    return {gc[NG], a ^ b ^ c};
  endfunction

  for (genvar k = 0; k < ETAPAS; k++) begin : stage_g
    localparam int W = N - k * SEG;   // operand bits not yet consumed on entry

    logic                 v_in_s;
    logic [W-1:0]         a_in_s;
    logic [W-1:0]         b_in_s;
    logic                 m_in_s;
    logic                 c_in_s;
    logic [SEG-1:0]       b_seg_s;
    logic [SEG-1:0]       seg_sum_s;
    logic                 seg_cout_s;
    logic [(k+1)*SEG-1:0] sum_nx_s;
    logic                 adv_s;
    logic                 valid_r;

    if (k == 0) begin : g_first
      assign v_in_s   = bus.valid_in;
      assign a_in_s   = bus.Operando1;
      assign b_in_s   = bus.Operando2;
      assign m_in_s   = bus.Modo;
      assign c_in_s   = bus.Modo ? ~bus.CarryIn : bus.CarryIn;
      assign sum_nx_s = seg_sum_s;
    end else begin : g_next
      assign v_in_s   = stage_g[k-1].valid_r;
      assign a_in_s   = stage_g[k-1].g_pass.a_r;
      assign b_in_s   = stage_g[k-1].g_pass.b_r;
      assign m_in_s   = stage_g[k-1].g_pass.modo_r;
      assign c_in_s   = stage_g[k-1].g_pass.carry_r;
      assign sum_nx_s = {seg_sum_s, stage_g[k-1].g_pass.sum_r};
    end

    // subtraction adds the inverted B, one segment at a time
    assign b_seg_s = m_in_s ? ~b_in_s[SEG-1:0] : b_in_s[SEG-1:0];
    assign {seg_cout_s, seg_sum_s} = cla_seg(a_in_s[SEG-1:0], b_seg_s, c_in_s);

    if (k == ETAPAS - 1) begin : g_last
      logic [N-1:0] resultado_r;
      logic         carry_out_r;
      logic         overflow_r;
      logic         cero_r;
      logic         negativo_r;

      assign adv_s = ~valid_r | bus.ready_in;

      // Output stage. The result and flags load only with a new beat and hold while stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_r     <= 1'b0;
          resultado_r <= {N{1'b0}};
          carry_out_r <= 1'b0;
          overflow_r  <= 1'b0;
          cero_r      <= 1'b0;
          negativo_r  <= 1'b0;
        end else if (adv_s) begin
          valid_r <= v_in_s;
          if (v_in_s) begin
            resultado_r <= sum_nx_s;
            carry_out_r <= seg_cout_s;
            overflow_r  <= (a_in_s[SEG-1] == b_seg_s[SEG-1]) & (sum_nx_s[N-1] != a_in_s[SEG-1]);
            cero_r      <= (sum_nx_s == {N{1'b0}});
            negativo_r  <= sum_nx_s[N-1];
          end
        end
      end

      assign bus.valid_out = valid_r;
      assign bus.Resultado = resultado_r;
      assign bus.CarryOut  = carry_out_r;
      assign bus.Overflow  = overflow_r;
      assign bus.Cero      = cero_r;
      assign bus.Negativo  = negativo_r;
    end else begin : g_pass
      logic [W-SEG-1:0]     a_r;
      logic [W-SEG-1:0]     b_r;
      logic [(k+1)*SEG-1:0] sum_r;
      logic                 modo_r;
      logic                 carry_r;

      assign adv_s = ~valid_r | stage_g[k+1].adv_s;

      // Intermediate stage. It keeps the partial sum, the segment carry and the remaining operand bits.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_r <= 1'b0;
          a_r     <= {(W-SEG){1'b0}};
          b_r     <= {(W-SEG){1'b0}};
          sum_r   <= {((k+1)*SEG){1'b0}};
          modo_r  <= 1'b0;
          carry_r <= 1'b0;
        end else if (adv_s) begin
          valid_r <= v_in_s;
          if (v_in_s) begin
            a_r     <= a_in_s[W-1:SEG];
            b_r     <= b_in_s[W-1:SEG];
            sum_r   <= sum_nx_s;
            modo_r  <= m_in_s;
            carry_r <= seg_cout_s;
          end
        end
      end
    end
  end

  assign bus.ready_out = stage_g[0].adv_s;

endmodule

// File: tb/tb_sumador_cla_segmentado.sv
// Directed bench for sumador_cla_segmentado. The main instance uses the default
// parameters. Three extra instances (ETAPAS = 1, 2, 8) share its operands for
// the carry-chain check.
module tb_sumador_cla_segmentado;

  logic clk;
  logic rst;
  logic vx;
  int   n_assert;
  int   n_fail;

  sumador_cla_segmentado_if #(.N(32)) dut_if ();
  sumador_cla_segmentado_if #(.N(32)) x1_if ();
  sumador_cla_segmentado_if #(.N(32)) x2_if ();
  sumador_cla_segmentado_if #(.N(32)) x8_if ();

  sumador_cla_segmentado #(.N(32), .ETAPAS(4), .BLOQUE(4)) dut (.clk(clk), .rst(rst), .bus(dut_if));
  sumador_cla_segmentado #(.N(32), .ETAPAS(1), .BLOQUE(4)) dut1 (.clk(clk), .rst(rst), .bus(x1_if));
  sumador_cla_segmentado #(.N(32), .ETAPAS(2), .BLOQUE(4)) dut2 (.clk(clk), .rst(rst), .bus(x2_if));
  sumador_cla_segmentado #(.N(32), .ETAPAS(8), .BLOQUE(4)) dut8 (.clk(clk), .rst(rst), .bus(x8_if));

  assign x1_if.Operando1 = dut_if.Operando1;
  assign x1_if.Operando2 = dut_if.Operando2;
  assign x1_if.CarryIn   = dut_if.CarryIn;
  assign x1_if.Modo      = dut_if.Modo;
  assign x1_if.valid_in  = vx;
  assign x1_if.ready_in  = 1'b1;
  assign x2_if.Operando1 = dut_if.Operando1;
  assign x2_if.Operando2 = dut_if.Operando2;
  assign x2_if.CarryIn   = dut_if.CarryIn;
  assign x2_if.Modo      = dut_if.Modo;
  assign x2_if.valid_in  = vx;
  assign x2_if.ready_in  = 1'b1;
  assign x8_if.Operando1 = dut_if.Operando1;
  assign x8_if.Operando2 = dut_if.Operando2;
  assign x8_if.CarryIn   = dut_if.CarryIn;
  assign x8_if.Modo      = dut_if.Modo;
  assign x8_if.valid_in  = vx;
  assign x8_if.ready_in  = 1'b1;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // golden arithmetic: {carry, result}
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic modo);
    logic [31:0] bb;
    logic        cc;
    bb = modo ? ~b : b;
    cc = modo ? ~cin : cin;
    return {1'b0, a} + {1'b0, bb} + {32'd0, cc};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic modo);
    dut_if.Operando1 = a;
    dut_if.Operando2 = b;
    dut_if.CarryIn   = cin;
    dut_if.Modo      = modo;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic modo, input logic [31:0] er,
                         input logic eco, input logic eov, input logic ez, input logic en);
    int lat;
    @(posedge clk); #1;
    chk({tag, "/ready_out"}, {63'd0, dut_if.ready_out}, 64'd1);
    drive(a, b, cin, modo);
    dut_if.valid_in = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) dut_if.valid_in = 1'b0;
      if (dut_if.valid_out) break;
    end
    chk({tag, "/latency"},  64'(lat), 64'd4);
    chk({tag, "/Resultado"}, {32'd0, dut_if.Resultado}, {32'd0, er});
    chk({tag, "/CarryOut"}, {63'd0, dut_if.CarryOut}, {63'd0, eco});
    chk({tag, "/Overflow"}, {63'd0, dut_if.Overflow}, {63'd0, eov});
    chk({tag, "/Cero"},     {63'd0, dut_if.Cero},     {63'd0, ez});
    chk({tag, "/Negativo"}, {63'd0, dut_if.Negativo}, {63'd0, en});
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic        sc [8];
  logic        sm [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent;
    int          recv;
    int          stale;
    logic        saw_low;
    logic        hold_valid;
    logic [35:0] snap;
    logic [32:0] ex;
    int          l1, l2, l4, l8;
    logic [31:0] r1, r2, r4, r8;

    n_assert = 0;
    n_fail   = 0;
    clk = 1'b0;
    rst = 1'b0;
    vx  = 1'b0;
    dut_if.valid_in = 1'b0;
    dut_if.ready_in = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    sa[0] = 32'h12345678; sb[0] = 32'h9ABCDEF0; sc[0] = 1'b0; sm[0] = 1'b0;
    sa[1] = 32'hFFFF0000; sb[1] = 32'h0000FFFF; sc[1] = 1'b0; sm[1] = 1'b1;
    sa[2] = 32'h80000000; sb[2] = 32'h80000000; sc[2] = 1'b1; sm[2] = 1'b0;
    sa[3] = 32'h00000010; sb[3] = 32'h00000020; sc[3] = 1'b1; sm[3] = 1'b1;
    sa[4] = 32'hDEADBEEF; sb[4] = 32'h01234567; sc[4] = 1'b0; sm[4] = 1'b0;
    sa[5] = 32'h0F0F0F0F; sb[5] = 32'hF0F0F0F0; sc[5] = 1'b0; sm[5] = 1'b1;
    sa[6] = 32'h7FFFFFFF; sb[6] = 32'h7FFFFFFF; sc[6] = 1'b1; sm[6] = 1'b0;
    sa[7] = 32'h00000001; sb[7] = 32'h00000000; sc[7] = 1'b0; sm[7] = 1'b1;

    // reset state
    #1 rst = 1'b1;
    #12;
    chk("rst/valid_out", {63'd0, dut_if.valid_out}, 64'd0);
    chk("rst/Resultado", {32'd0, dut_if.Resultado}, 64'd0);
    chk("rst/flags", {60'd0, dut_if.CarryOut, dut_if.Overflow, dut_if.Cero, dut_if.Negativo}, 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst/ready_out", {63'd0, dut_if.ready_out}, 64'd1);

    // directed single beats
    run_one("wrap_to_zero", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("pos_overflow", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_one("sub_5_7",      32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_one("sub_7_5",      32'd7, 32'd5, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0);
    run_one("sub_borrow",   32'd0, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_one("neg_overflow", 32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // back-to-back stream with a downstream stall
    sent = 0; recv = 0; saw_low = 1'b0; hold_valid = 1'b0; snap = 36'd0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(posedge clk); #1;
      dut_if.ready_in = !(cyc >= 3 && cyc <= 5);
      if (sent < 8) begin
        drive(sa[sent], sb[sent], sc[sent], sm[sent]);
        dut_if.valid_in = 1'b1;
      end else begin
        dut_if.valid_in = 1'b0;
      end
      @(negedge clk);
      if (!dut_if.ready_out) saw_low = 1'b1;
      if (dut_if.valid_out && !dut_if.ready_in) begin
        if (hold_valid)
          chk("stall_stable", {28'd0, dut_if.Resultado, dut_if.CarryOut, dut_if.Overflow,
                               dut_if.Cero, dut_if.Negativo}, {28'd0, snap});
        else begin
          snap = {dut_if.Resultado, dut_if.CarryOut, dut_if.Overflow, dut_if.Cero, dut_if.Negativo};
          hold_valid = 1'b1;
        end
      end else begin
        hold_valid = 1'b0;
      end
      if (dut_if.valid_out && dut_if.ready_in) begin
        ex = model(sa[recv], sb[recv], sc[recv], sm[recv]);
        chk($sformatf("stream%0d/Resultado", recv), {32'd0, dut_if.Resultado}, {32'd0, ex[31:0]});
        chk($sformatf("stream%0d/CarryOut", recv), {63'd0, dut_if.CarryOut}, {63'd0, ex[32]});
        recv++;
      end
      if (dut_if.valid_in && dut_if.ready_out) sent++;
    end
    dut_if.valid_in = 1'b0;
    dut_if.ready_in = 1'b1;
    chk("stream/count", 64'(recv), 64'd8);
    chk("stream/ready_out_drop", {63'd0, saw_low}, 64'd1);

    // carry across every segment and group boundary, four pipeline depths
    @(posedge clk); #1;
    drive(32'h0FFFFFFF, 32'h00000001, 1'b1, 1'b0);
    dut_if.valid_in = 1'b1;
    vx = 1'b1;
    chk("chain/ready_x1", {63'd0, x1_if.ready_out}, 64'd1);
    chk("chain/ready_x8", {63'd0, x8_if.ready_out}, 64'd1);
    l1 = 0; l2 = 0; l4 = 0; l8 = 0;
    r1 = 32'd0; r2 = 32'd0; r4 = 32'd0; r8 = 32'd0;
    for (int cy = 1; cy <= 12; cy++) begin
      @(posedge clk); #1;
      if (cy == 1) begin
        dut_if.valid_in = 1'b0;
        vx = 1'b0;
      end
      if (x1_if.valid_out  && l1 == 0) begin l1 = cy; r1 = x1_if.Resultado; end
      if (x2_if.valid_out  && l2 == 0) begin l2 = cy; r2 = x2_if.Resultado; end
      if (dut_if.valid_out && l4 == 0) begin l4 = cy; r4 = dut_if.Resultado; end
      if (x8_if.valid_out  && l8 == 0) begin l8 = cy; r8 = x8_if.Resultado; end
    end
    chk("chain/lat_e1", 64'(l1), 64'd1);
    chk("chain/lat_e2", 64'(l2), 64'd2);
    chk("chain/lat_e4", 64'(l4), 64'd4);
    chk("chain/lat_e8", 64'(l8), 64'd8);
    chk("chain/res_e1", {32'd0, r1}, 64'h10000001);
    chk("chain/res_e2", {32'd0, r2}, 64'h10000001);
    chk("chain/res_e4", {32'd0, r4}, 64'h10000001);
    chk("chain/res_e8", {32'd0, r8}, 64'h10000001);

    // reset with three beats in flight
    run_one("pre_reset", 32'h00000001, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(sa[i], sb[i], sc[i], sm[i]);
      dut_if.valid_in = 1'b1;
      @(posedge clk); #1;
    end
    dut_if.valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst/valid_out", {63'd0, dut_if.valid_out}, 64'd0);
    chk("midrst/Resultado", {32'd0, dut_if.Resultado}, 64'd0);
    chk("midrst/flags", {60'd0, dut_if.CarryOut, dut_if.Overflow, dut_if.Cero, dut_if.Negativo}, 64'd0);
    @(negedge clk) rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (dut_if.valid_out) stale++;
    end
    chk("midrst/stale_beats", 64'(stale), 64'd0);
    run_one("post_reset", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
